// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding (IEEE 1149.1 reference codes), opcodes,
// data-register select and the TAP next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SHIFT_DR = 4'h2,
        ST_EXIT1_DR = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EXIT2_DR = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SHIFT_IR = 4'hA,
        ST_EXIT1_IR = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EXIT2_IR = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_t;

    localparam int unsigned OP_EXTEST = 0;
    localparam int unsigned OP_SAMPLE = 1;
    localparam int unsigned OP_IDCODE = 2;

    typedef enum logic [1:0] {
        DR_BSR,
        DR_ID,
        DR_BYP
    } dr_sel_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = ST_TLR;
        case (s)
            ST_TLR:      n = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      n = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   n = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: n = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: n = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: n = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   n = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   n = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: n = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: n = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: n = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   n = tms ? ST_SEL_DR   : ST_RTI;
            default:     n = ST_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchronizer for an asynchronous JTAG pin plus registered edge pulses,
// so rise/fall appear one iclk wide, three iclk after the pin edge.
module jtag_sync_edge (
    input  logic iclk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

    assign level = sync;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller run in the iclk domain: FSM, IR, IDCODE/BYPASS registers,
// boundary-scan strobes and TDO mux.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic iclk,
    input  logic resetn,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_en,
    input  logic bsr_tdo,
    output logic bsr_tdi,
    output logic shift_dr,
    output logic clk_dr,
    output logic update_dr,
    output logic mode
);

    logic tck_s, tck_rise, tck_fall;
    logic tms_s, tms_rise, tms_fall;
    logic tdi_s, tdi_rise, tdi_fall;
    logic unused_edges;

    jtag_sync_edge u_sync_tck (.iclk(iclk), .resetn(resetn), .din(tck),
                               .level(tck_s), .rise(tck_rise), .fall(tck_fall));
    jtag_sync_edge u_sync_tms (.iclk(iclk), .resetn(resetn), .din(tms),
                               .level(tms_s), .rise(tms_rise), .fall(tms_fall));
    jtag_sync_edge u_sync_tdi (.iclk(iclk), .resetn(resetn), .din(tdi),
                               .level(tdi_s), .rise(tdi_rise), .fall(tdi_fall));

    assign unused_edges = ^{tck_s, tms_rise, tms_fall, tdi_rise, tdi_fall};

    tap_state_t        state;
    tap_state_t        state_nxt;
    logic [IR_W-1:0]   ir_sr;
    logic [IR_W-1:0]   ir_act;
    logic [31:0]       id_sr;
    logic              byp;
    dr_sel_t           dr_sel;
    logic              bsr_sel;
    logic              dr_lsb;

    always_comb begin
        state_nxt = tap_next(state, tms_s);
    end

    always_comb begin
        dr_sel = DR_BYP;
        if (ir_act == IR_W'(OP_EXTEST) || ir_act == IR_W'(OP_SAMPLE))
            dr_sel = DR_BSR;
        else if (ir_act == IR_W'(OP_IDCODE))
            dr_sel = DR_ID;
    end

    always_comb begin
        dr_lsb = byp;
        case (dr_sel)
            DR_BSR:  dr_lsb = bsr_tdo;
            DR_ID:   dr_lsb = id_sr[0];
            default: dr_lsb = byp;
        endcase
    end

    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn)
            state <= ST_TLR;
        else if (tck_rise)
            state <= state_nxt;
    end

    // IR shifts on TCK rise but only becomes active on the UPDATE_IR fall.
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            ir_sr  <= '0;
            ir_act <= IR_W'(OP_IDCODE);
        end else begin
            if (tck_rise) begin
                if (state == ST_CAP_IR)
                    ir_sr <= IR_W'(1);
                else if (state == ST_SHIFT_IR)
                    ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
                if (state_nxt == ST_TLR)
                    ir_act <= IR_W'(OP_IDCODE);
            end
            if (tck_fall && state == ST_UPD_IR)
                ir_act <= ir_sr;
        end
    end

    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            id_sr <= '0;
            byp   <= 1'b0;
        end else if (tck_rise) begin
            if (state == ST_CAP_DR) begin
                if (dr_sel == DR_ID)
                    id_sr <= IDCODE;
                if (dr_sel == DR_BYP)
                    byp <= 1'b0;
            end else if (state == ST_SHIFT_DR) begin
                if (dr_sel == DR_ID)
                    id_sr <= {tdi_s, id_sr[31:1]};
                if (dr_sel == DR_BYP)
                    byp <= tdi_s;
            end
        end
    end

    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (tck_fall) begin
            if (state == ST_SHIFT_IR) begin
                tdo    <= ir_sr[0];
                tdo_en <= 1'b1;
            end else if (state == ST_SHIFT_DR) begin
                tdo    <= dr_lsb;
                tdo_en <= 1'b1;
            end else begin
                tdo_en <= 1'b0;
            end
        end
    end

    assign bsr_sel   = (dr_sel == DR_BSR);
    assign shift_dr  = bsr_sel && (state == ST_SHIFT_DR);
    assign clk_dr    = bsr_sel && tck_rise && (state == ST_CAP_DR || state == ST_SHIFT_DR);
    assign update_dr = bsr_sel && tck_fall && (state == ST_UPD_DR);
    assign mode      = (ir_act == IR_W'(OP_EXTEST));
    assign bsr_tdi   = tdi_s;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized bench for jtag_tap_ctrl against a TCK-level behavioural TAP model.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    localparam logic [31:0] IDC = 32'h1000_0001;

    logic iclk = 1'b0;
    logic resetn = 1'b0;
    logic tck = 1'b0, tms = 1'b1, tdi = 1'b0, bsr_tdo = 1'b0;
    logic tdo, tdo_en, bsr_tdi, shift_dr, clk_dr, update_dr, mode;

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned cnt_cap = 0, cnt_shf = 0, cnt_upd = 0;

    always #5 iclk = ~iclk;

    jtag_tap_ctrl #(.IR_W(4), .IDCODE(IDC)) dut (
        .iclk(iclk), .resetn(resetn), .tck(tck), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en), .bsr_tdo(bsr_tdo), .bsr_tdi(bsr_tdi),
        .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr), .mode(mode)
    );

    always @(negedge iclk) begin
        if (clk_dr) begin
            if (shift_dr) cnt_shf++;
            else          cnt_cap++;
        end
        if (update_dr) cnt_upd++;
    end

    // Model: states 0 TLR,1 RTI,2..8 DR column, 9..15 IR column (standard diagram order).
    int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int          m_st;
    logic [3:0]  m_ir, m_irsr;
    logic [31:0] m_id;
    logic        m_byp, m_tdo, m_en;
    int unsigned e_cap = 0, e_shf = 0, e_upd = 0;

    function automatic int m_sel(input logic [3:0] ir);
        if (ir == 4'd0 || ir == 4'd1) return 0;
        if (ir == 4'd2) return 1;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic model_reset();
        m_st = 0; m_ir = 4'd2; m_irsr = '0; m_id = '0;
        m_byp = 1'b0; m_tdo = 1'b0; m_en = 1'b0;
    endtask

    task automatic model_step(input logic t_ms, input logic t_di);
        int sel;
        sel = m_sel(m_ir);
        case (m_st)
            3:  begin
                    if (sel == 0) e_cap++;
                    if (sel == 1) m_id = IDC;
                    if (sel == 2) m_byp = 1'b0;
                end
            4:  begin
                    if (sel == 0) e_shf++;
                    m_id  = {t_di, m_id[31:1]};
                    m_byp = t_di;
                end
            10: m_irsr = 4'b0001;
            11: m_irsr = {t_di, m_irsr[3:1]};
            default: ;
        endcase
        m_st = t_ms ? nx1[m_st] : nx0[m_st];
        if (m_st == 0) m_ir = 4'd2;
        if (m_st == 15) m_ir = m_irsr;
        sel = m_sel(m_ir);
        if (m_st == 8 && sel == 0) e_upd++;
        if (m_st == 11) begin
            m_tdo = m_irsr[0]; m_en = 1'b1;
        end else if (m_st == 4) begin
            m_en  = 1'b1;
            m_tdo = (sel == 0) ? bsr_tdo : (sel == 1) ? m_id[0] : m_byp;
        end else begin
            m_en = 1'b0;
        end
    endtask

    task automatic check_all();
        check("tdo",     tdo,    m_tdo);
        check("tdo_en",  tdo_en, m_en);
        check("mode",    mode,   (m_ir == 4'd0));
        check("ir",      dut.ir_act, m_ir);
        check("in_tlr",  (dut.state == ST_TLR), (m_st == 0));
        check("n_cap",   cnt_cap, e_cap);
        check("n_shift", cnt_shf, e_shf);
        check("n_upd",   cnt_upd, e_upd);
    endtask

    task automatic tck_cycle(input logic t_ms, input logic t_di);
        tms = t_ms; tdi = t_di; bsr_tdo = 1'($urandom_range(0, 1));
        wclk(6); tck = 1'b1;
        wclk(6); tck = 1'b0;
        wclk(6);
        model_step(t_ms, t_di);
        check_all();
    endtask

    // Starts and ends in RTI; returns the n tdo bits seen during SHIFT.
    task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                        output logic [31:0] dout);
        dout = '0;
        tck_cycle(1'b1, 1'b0);
        if (is_ir) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        dout[0] = tdo;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i]);
            if (i < n - 1) dout[i+1] = tdo;
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int unsigned c0, s0, u0;
        logic [3:0] ops[6];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'h9};

        model_reset();
        resetn = 1'b0;
        wclk(4);
        check("rst_tdo", tdo, 1'b0);
        check("rst_tdo_en", tdo_en, 1'b0);
        check("rst_clk_dr", clk_dr, 1'b0);
        check("rst_update_dr", update_dr, 1'b0);
        check("rst_shift_dr", shift_dr, 1'b0);
        check("rst_mode", mode, 1'b0);
        check("rst_ir", dut.ir_act, 4'd2);
        resetn = 1'b1;
        wclk(2);

        repeat (5) tck_cycle(1'b1, 1'($urandom_range(0, 1)));
        check("tlr_no_clk_dr", cnt_cap + cnt_shf, 0);
        check("tlr_no_upd", cnt_upd, 0);
        tck_cycle(1'b0, 1'b0);

        scan(1'b0, 32, $urandom, d);
        check("idcode_stream", d, IDC);

        scan(1'b1, 4, 32'hF, d);
        check("ir_capture", d[3:0], 4'b0001);
        scan(1'b0, 4, 32'b1101, d);
        check("bypass_F", d[3:0], 4'b1010);

        scan(1'b1, 4, 32'h7, d);
        scan(1'b0, 4, 32'b1101, d);
        check("bypass_7", d[3:0], 4'b1010);

        scan(1'b1, 4, 32'h0, d);
        check("extest_mode", mode, 1'b1);
        c0 = cnt_cap; s0 = cnt_shf; u0 = cnt_upd;
        scan(1'b0, 8, $urandom, d);
        check("extest_capture", cnt_cap - c0, 1);
        check("extest_shift", cnt_shf - s0, 8);
        check("extest_update", cnt_upd - u0, 1);

        for (int k = 0; k < 8; k++) begin
            scan(1'b1, 4, 32'(ops[$urandom_range(0, 5)]), d);
            scan(1'b0, $urandom_range(1, 32), $urandom, d);
        end

        repeat (150) tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (5) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);

        scan(1'b1, 4, 32'h0, d);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        repeat (3) tck_cycle(1'b0, 1'($urandom_range(0, 1)));
        u0 = cnt_upd;
        tdi = 1'b1;
        wclk(6); tck = 1'b1;
        wclk(2); resetn = 1'b0;
        wclk(1);
        model_reset();
        check("mid_rst_tdo", tdo, 1'b0);
        check("mid_rst_tdo_en", tdo_en, 1'b0);
        check("mid_rst_mode", mode, 1'b0);
        check("mid_rst_shift_dr", shift_dr, 1'b0);
        check("mid_rst_clk_dr", clk_dr, 1'b0);
        check("mid_rst_update_dr", update_dr, 1'b0);
        check("mid_rst_ir", dut.ir_act, 4'd2);
        tck = 1'b0;
        wclk(6);
        resetn = 1'b1;
        wclk(2);
        repeat (5) tck_cycle(1'b1, 1'b0);
        check("mid_rst_no_update", cnt_upd - u0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
